zx8x_tape_save: RTL and testbench

- Decodes the ZX80/ZX81 SAVE waveform (MIC level, driven from the vsync/ic11 latch) back into bytes.
- Lets the core capture a program the machine saves and stream it to the ARM side for upload. This is the reverse of the tape-load path.
- Counts pulses per bit burst, assembles bytes MSB first, and buffers them in a small FIFO with a valid/ready output.

---
 rtl/zx8x_tape_save.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_zx8x_tape_save.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx8x_tape_save.sv
// -----------------------------------------------------------------------------
// zx8x_tape_save
//
// Decodes the ZX80/ZX81 SAVE waveform (MIC level) back into bytes so the
// core can capture a program being saved and stream it to the ARM side.
// Each bit is a burst of pulses followed by a silent gap. Short bursts
// (<= SPLIT pulses) decode as 0 and long bursts as 1. Bits are assembled
// MSB first and the finished bytes are queued in a small FIFO that has a
// valid/ready output.
//
// Optional feature macro: TAPE_SAVE_NAME_SKIP_EN
//   When this macro is defined and zx81 = 1, the program-name bytes at the
//   start of the file are dropped. That covers every byte up to and including
//   the first byte with bit7 = 1, so the FIFO carries only .p file content.
//
// Ports:
//   clk_sys       system clock
//   reset         synchronous, active-high reset
//   ce            tick strobe; every timing count advances only on ce
//   enable        arms the decoder; 0 holds the block in IDLE and flushes the FIFO
//   zx81          model select (gates the optional name skip)
//   mic_in        MIC level, 1 = pulse high (asynchronous)
//   dout          FIFO head byte (registered)
//   dout_valid    FIFO not empty
//   dout_ready    consumer takes dout when dout_valid and dout_ready are both 1
//   busy          decoder is inside a file (BURST or GAP)
//   done          one-cycle pulse at end of file
//   err_partial   sticky: the file ended with a partial byte
//   err_overflow  sticky: a byte completed while the FIFO was full
//   byte_count    bytes pushed since the decoder was armed (saturating)
// -----------------------------------------------------------------------------
module zx8x_tape_save #(
    parameter int CE_HZ      = 3250000,
    parameter int HIGH_MIN   = 160,
    parameter int BIT_GAP    = 1000,
    parameter int EOF_TICKS  = 32500,
    parameter int SPLIT      = 6,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable,
    input  logic        zx81,
    input  logic        mic_in,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done,
    output logic        err_partial,
    output logic        err_overflow,
    output logic [15:0] byte_count
);
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    localparam logic [15:0]         HIGH_MIN_T = 16'(HIGH_MIN);
    localparam logic [15:0]         BIT_GAP_T  = 16'(BIT_GAP);
    localparam logic [15:0]         EOF_T      = 16'(EOF_TICKS);
    localparam logic [3:0]          SPLIT_T    = 4'(SPLIT);
    localparam logic [DEPTH_LOG2:0] FIFO_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FIFO_ONE   = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // CE_HZ only documents the tick values; it is not used in the logic.
    logic [31:0] unused_ce_hz;
    assign unused_ce_hz = 32'(CE_HZ);

    // ---------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] mic_sync_reg;
    logic [SYNC_STAGES-1:0] mic_sync_next;
    logic                   mic_prev_reg;
    logic                   mic_s;

    assign mic_sync_next[0] = mic_in;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign mic_sync_next[gi] = mic_sync_reg[gi-1];
        end
    endgenerate

    assign mic_s = mic_sync_reg[SYNC_STAGES-1];

    logic [15:0] high_cnt_reg;
    logic [15:0] low_cnt_reg;
    logic        mic_rise;
    logic        pulse_ok;

    assign mic_rise = mic_s & ~mic_prev_reg;
    // A pulse counts only when its high phase was long enough. It is judged
    // on the falling edge, so a glitch is dropped as a whole.
    assign pulse_ok = mic_prev_reg & ~mic_s & (high_cnt_reg >= HIGH_MIN_T);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mic_sync_reg <= '0;
            mic_prev_reg <= 1'b0;
            high_cnt_reg <= '0;
            low_cnt_reg  <= '0;
        end else begin
            mic_sync_reg <= mic_sync_next;
            mic_prev_reg <= mic_s;
            if (mic_rise) begin
                high_cnt_reg <= '0;
            end else if (mic_s && ce && (high_cnt_reg != 16'hFFFF)) begin
                high_cnt_reg <= high_cnt_reg + 16'd1;
            end
            // Counts time since the last real pulse ended. Glitches do not
            // restart it, so a gap that contains a glitch is still measured
            // as one gap.
            if (pulse_ok) begin
                low_cnt_reg <= '0;
            end else if (ce && (low_cnt_reg != 16'hFFFF)) begin
                low_cnt_reg <= low_cnt_reg + 16'd1;
            end
        end
    end

    // Thresholds are only tested while the line is low. A line that stays
    // high never closes a bit or the file.
    logic gap_hit;
    logic eof_hit;
    assign gap_hit = ~mic_s & (low_cnt_reg >= BIT_GAP_T);
    assign eof_hit = ~mic_s & (low_cnt_reg >= EOF_T);

    // ---------------------------------------------------------------------
    // Burst/gap state machine
    // ---------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   arm;
    logic   pulse_restart;
    logic   pulse_inc;
    logic   bit_close;
    logic   file_end;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        arm           = 1'b0;
        pulse_restart = 1'b0;
        pulse_inc     = 1'b0;
        bit_close     = 1'b0;
        file_end      = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pulse_ok) begin
                        arm        = 1'b1;
                        state_next = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (pulse_ok) begin
                        pulse_inc = 1'b1;
                    end else if (gap_hit) begin
                        bit_close  = 1'b1;
                        state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (pulse_ok) begin
                        pulse_restart = 1'b1;
                        state_next    = ST_BURST;
                    end else if (eof_hit) begin
                        file_end   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Bit and byte assembly
    // ---------------------------------------------------------------------
    logic [3:0]  pulse_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [6:0]  shift_reg;
    logic        new_bit;
    logic        byte_done;
    logic [7:0]  byte_value;
    logic        skip_now;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        done_reg;
    logic        err_partial_reg;
    logic        err_overflow_reg;
    logic [15:0] byte_count_reg;

    assign new_bit    = (pulse_cnt_reg > SPLIT_T);
    assign byte_done  = bit_close & (bit_cnt_reg == 3'd7);
    assign byte_value = {shift_reg, new_bit};
    assign push_req   = byte_done & ~skip_now;

`ifdef TAPE_SAVE_NAME_SKIP_EN
    // Set at the start of every file. It clears once the byte that ends the
    // ZX81 program name (bit7 set) has gone by. That byte is dropped too.
    logic skip_pending_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            skip_pending_reg <= 1'b0;
        end else if (arm) begin
            skip_pending_reg <= 1'b1;
        end else if (byte_done && zx81 && byte_value[7]) begin
            skip_pending_reg <= 1'b0;
        end
    end

    assign skip_now = skip_pending_reg & zx81;
`else
    logic unused_zx81;
    assign unused_zx81 = zx81;
    assign skip_now    = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pulse_cnt_reg    <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            done_reg         <= 1'b0;
            err_partial_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
            byte_count_reg   <= '0;
        end else begin
            done_reg <= file_end;

            if (arm || pulse_restart) begin
                pulse_cnt_reg <= 4'd1;
            end else if (pulse_inc && (pulse_cnt_reg != 4'hF)) begin
                pulse_cnt_reg <= pulse_cnt_reg + 4'd1;
            end

            if (arm) begin
                bit_cnt_reg <= '0;
            end else if (bit_close) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (bit_close) begin
                shift_reg <= {shift_reg[5:0], new_bit};
            end

            if (arm) begin
                err_partial_reg <= 1'b0;
            end else if (file_end && (bit_cnt_reg != 3'd0)) begin
                err_partial_reg <= 1'b1;
            end

            if (arm) begin
                err_overflow_reg <= 1'b0;
            end else if (push_req && !push_ok) begin
                err_overflow_reg <= 1'b1;
            end

            if (arm) begin
                byte_count_reg <= '0;
            end else if (push_ok && (byte_count_reg != 16'hFFFF)) begin
                byte_count_reg <= byte_count_reg + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output FIFO. The head byte is held in a register so that dout has a
    // clean registered path. The register is reloaded from the array after a
    // pop, or bypassed from the incoming byte when that byte becomes the head.
    // ---------------------------------------------------------------------
    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [7:0]            dout_reg;

    assign rd_ptr_next = rd_ptr_reg + 1'b1;
    assign pop         = dout_ready & (count_reg != '0);
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign push_ok     = push_req & ((count_reg != FIFO_FULL) | pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= byte_value;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + FIFO_ONE;
                2'b01:   count_reg <= count_reg - FIFO_ONE;
                default: count_reg <= count_reg;
            endcase
            if (pop && (count_reg > FIFO_ONE)) begin
                dout_reg <= fifo_mem[rd_ptr_next];
            end else if (push_ok && ((count_reg == '0) || ((count_reg == FIFO_ONE) && pop))) begin
                dout_reg <= byte_value;
            end
        end
    end

    assign dout         = dout_reg;
    assign dout_valid   = (count_reg != '0);
    assign busy         = (state_reg == ST_BURST) || (state_reg == ST_GAP);
    assign done         = done_reg;
    assign err_partial  = err_partial_reg;
    assign err_overflow = err_overflow_reg;
    assign byte_count   = byte_count_reg;

endmodule

// File: tb/tb_zx8x_tape_save.sv
module tb_zx8x_tape_save;
    // Scaled-down timing so the run stays short.
    localparam int HIGH_MIN   = 5;
    localparam int BIT_GAP    = 30;
    localparam int EOF_TICKS  = 150;
    localparam int SPLIT      = 6;
    localparam int DEPTH_LOG2 = 2;

    // Waveform timing, in ce ticks.
    localparam int T_HIGH   = 8;
    localparam int T_LOW    = 8;
    localparam int T_GLITCH = 2;
    localparam int T_BITGAP = 45;
    localparam int T_EOF    = 190;

`ifdef TAPE_SAVE_NAME_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        enable = 1'b0;
    logic        zx81 = 1'b0;
    logic        mic_in = 1'b0;
    logic        dout_ready = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        busy;
    logic        done;
    logic        err_partial;
    logic        err_overflow;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int ready_mode = 0;   // 0: ready low, 1: random ready, 2: one pop then low

    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_count;
    bit         exp_ovf;

    zx8x_tape_save #(
        .CE_HZ(3250000), .HIGH_MIN(HIGH_MIN), .BIT_GAP(BIT_GAP),
        .EOF_TICKS(EOF_TICKS), .SPLIT(SPLIT), .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .enable(enable),
        .zx81(zx81), .mic_in(mic_in), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done),
        .err_partial(err_partial), .err_overflow(err_overflow),
        .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    // ce is asserted on about 3 of every 4 cycles.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            ce = ($urandom_range(0, 3) != 0);
        end
    end

    // Consumer: drives ready, logs every handshake and counts done pulses.
    initial begin
        forever begin
            @(negedge clk_sys);
            case (ready_mode)
                1: dout_ready = 1'($urandom_range(0, 1));
                2: begin dout_ready = 1'b1; ready_mode = 0; end
                default: dout_ready = 1'b0;
            endcase
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (done) done_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Holds mic_in at a level for a given number of ce ticks (negedge aligned).
    task automatic hold(input logic level, input int ticks);
        int n;
        n = 0;
        mic_in = level;
        while (n < ticks) begin
            if (ce) n++;
            @(negedge clk_sys);
        end
    endtask

    task automatic send_bit(input int npulses, input bit glitch);
        for (int p = 0; p < npulses; p++) begin
            if (p != 0) begin
                if (glitch && ($urandom_range(0, 1) == 1)) begin
                    hold(1'b0, 3);
                    hold(1'b1, T_GLITCH);
                    hold(1'b0, 3);
                end else begin
                    hold(1'b0, T_LOW);
                end
            end
            hold(1'b1, T_HIGH);
        end
        hold(1'b0, T_BITGAP);
    endtask

    function automatic int rand_pulses(input logic b);
        return b ? int'($urandom_range(SPLIT + 1, 12)) : int'($urandom_range(1, SPLIT));
    endfunction

    task automatic send_sent(input bit glitch);
        for (int i = 0; i < sent_q.size(); i++) begin
            for (int k = 7; k >= 0; k--) send_bit(rand_pulses(sent_q[i][k]), glitch);
        end
    endtask

    task automatic end_file();
        hold(1'b0, T_EOF);
        repeat (20) @(negedge clk_sys);
    endtask

    task automatic start_test();
        got_q.delete();
        sent_q.delete();
        done_seen = 0;
    endtask

    // Reference: which bytes the consumer should see, given the bytes that
    // were sent, the name skip rule and a FIFO capacity (used when nothing drains).
    function automatic void model_stream(input bit zx81_v, input int cap);
        bit skipping;
        skipping = zx81_v && SKIP_EN;
        exp_q.delete();
        exp_ovf = 1'b0;
        foreach (sent_q[i]) begin
            if (skipping) begin
                if (sent_q[i][7]) skipping = 1'b0;
            end else if (exp_q.size() < cap) begin
                exp_q.push_back(sent_q[i]);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        exp_count = exp_q.size();
    endfunction

    task automatic compare_stream(input string tag);
        check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int pat[8];
        pat = '{9, 4, 9, 4, 4, 4, 4, 9};

        // ---- reset state
        repeat (4) @(negedge clk_sys);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_valid", 32'(dout_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err_partial", 32'(err_partial), 0);
        check_eq("rst_err_overflow", 32'(err_overflow), 0);
        check_eq("rst_byte_count", 32'(byte_count), 0);
        reset = 1'b0;
        enable = 1'b1;
        hold(1'b0, 20);

        // ---- single 0x00 byte, four pulses per bit
        start_test();
        ready_mode = 1;
        sent_q.push_back(8'h00);
        for (int k = 0; k < 8; k++) send_bit(4, 1'b0);
        end_file();
        model_stream(1'b0, 1000);
        compare_stream("zero");
        check_eq("zero_byte_count", 32'(byte_count), 32'(exp_count));
        check_eq("zero_done", 32'(done_seen), 1);
        check_eq("zero_err_partial", 32'(err_partial), 0);
        check_eq("zero_err_overflow", 32'(err_overflow), 0);
        check_eq("zero_busy", 32'(busy), 0);

        // ---- 0xA1 held in the FIFO, then one pop
        start_test();
        ready_mode = 0;
        sent_q.push_back(8'hA1);
        for (int k = 0; k < 8; k++) send_bit(pat[k], 1'b0);
        check_eq("a1_valid", 32'(dout_valid), 1);
        check_eq("a1_dout", 32'(dout), 32'h0A1);
        end_file();
        ready_mode = 2;
        repeat (3) @(negedge clk_sys);
        check_eq("a1_valid_after_pop", 32'(dout_valid), 0);
        model_stream(1'b0, 1000);
        compare_stream("a1");

        // ---- three bytes plus five bits
        start_test();
        ready_mode = 1;
        for (int i = 0; i < 3; i++) sent_q.push_back(8'($urandom_range(0, 255)));
        send_sent(1'b0);
        for (int k = 0; k < 5; k++) send_bit(rand_pulses(1'($urandom_range(0, 1))), 1'b0);
        end_file();
        model_stream(1'b0, 1000);
        compare_stream("partial");
        check_eq("partial_err", 32'(err_partial), 1);
        check_eq("partial_done", 32'(done_seen), 1);
        check_eq("partial_byte_count", 32'(byte_count), 32'(exp_count));

        // ---- overflow: five bytes, nothing drained
        start_test();
        ready_mode = 0;
        for (int i = 0; i < 5; i++) sent_q.push_back(8'($urandom_range(0, 255)));
        send_sent(1'b0);
        end_file();
        model_stream(1'b0, 1 << DEPTH_LOG2);
        check_eq("ovf_err", 32'(err_overflow), 32'(exp_ovf));
        check_eq("ovf_byte_count", 32'(byte_count), 32'(exp_count));
        ready_mode = 1;
        repeat (40) @(negedge clk_sys);
        compare_stream("ovf");

        // ---- glitches inside bursts
        start_test();
        ready_mode = 1;
        for (int i = 0; i < 2; i++) sent_q.push_back(8'($urandom_range(0, 255)));
        send_sent(1'b1);
        end_file();
        model_stream(1'b0, 1000);
        compare_stream("glitch");
        check_eq("glitch_err_partial", 32'(err_partial), 0);

        // ---- ZX81 name bytes, zx81 = 1 then zx81 = 0
        for (int z = 1; z >= 0; z--) begin
            start_test();
            ready_mode = 1;
            zx81 = 1'(z);
            sent_q.push_back(8'h26);
            sent_q.push_back(8'hB7);
            sent_q.push_back(8'h00);
            sent_q.push_back(8'h01);
            send_sent(1'b0);
            end_file();
            model_stream(1'(z), 1000);
            compare_stream($sformatf("name_zx81_%0d", z));
            check_eq($sformatf("name_zx81_%0d_byte_count", z), 32'(byte_count), 32'(exp_count));
        end
        zx81 = 1'b0;

        // ---- enable dropped mid-file
        start_test();
        ready_mode = 0;
        sent_q.push_back(8'($urandom_range(0, 255)));
        send_sent(1'b0);
        for (int k = 0; k < 3; k++) send_bit(rand_pulses(1'b1), 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge clk_sys);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_valid", 32'(dout_valid), 0);
        check_eq("abort_byte_count", 32'(byte_count), 1);
        check_eq("abort_done", 32'(done_seen), 0);
        enable = 1'b1;
        hold(1'b0, T_EOF);

        // ---- mic held high inside a burst
        start_test();
        ready_mode = 1;
        hold(1'b1, T_HIGH);
        hold(1'b0, T_LOW);
        hold(1'b1, 300);
        check_eq("stuck_busy", 32'(busy), 1);
        check_eq("stuck_done", 32'(done_seen), 0);
        hold(1'b0, T_BITGAP);
        end_file();
        check_eq("stuck_err_partial", 32'(err_partial), 1);
        check_eq("stuck_done_end", 32'(done_seen), 1);
        check_eq("stuck_busy_end", 32'(busy), 0);
        check_eq("stuck_byte_count", 32'(byte_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
